// File: rtl/piano_pkg.sv
// Shared types and constants for the piano tone generator: FSM state encoding,
// the no-note code and the half-period table (index 0 = lowest note).
package piano_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2
    } piano_state_t;

    localparam int NOTE_NONE = 0;
    localparam int MAX_KEYS  = 15;

    // Half-periods at 100 MHz, C4 upwards; entries past C5 serve builds with more than 8 keys.
    localparam logic [31:0] DIV_TABLE [MAX_KEYS] = '{
        32'd191110, 32'd170265, 32'd151685, 32'd143172, 32'd127551,
        32'd113636, 32'd101239, 32'd95557,  32'd85131,  32'd75843,
        32'd71586,  32'd63776,  32'd56818,  32'd50619,  32'd47778
    };

endpackage

// File: rtl/piano_voice_if.sv
// Control/tone bundle of the piano voice. Inputs are static levels (no handshake):
// sw/octave/arp_mode are sampled every clock, FREQ/note/note_valid/dbg_state update every clock.
interface piano_voice_if #(
    parameter int NUM_KEYS = 8
);
    import piano_pkg::*;

    localparam int NOTE_W = $clog2(NUM_KEYS + 1);

    logic [NUM_KEYS-1:0] sw;
    logic [1:0]          octave;
    logic                arp_mode;
    logic                FREQ;
    logic [NOTE_W-1:0]   note;
    logic                note_valid;
    piano_state_t        dbg_state;

    modport master (output sw, octave, arp_mode, input FREQ, note, note_valid, dbg_state);
    modport slave  (input sw, octave, arp_mode, output FREQ, note, note_valid, dbg_state);

endinterface

// File: rtl/piano_debounce.sv
// One key: two-flop synchroniser followed by a counter that accepts a new level
// only after DEB_CYCLES consecutive equal samples.
module piano_debounce #(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            clean <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/piano_voice.sv
// Piano voice: debounced keys -> note select (priority, or arpeggio when built
// with PIANO_ARP_EN) -> glitch-free square wave on FREQ with octave shift.
module piano_voice
    import piano_pkg::*;
#(
    parameter int NUM_KEYS      = 8,
    parameter int DIV_W         = 18,
    parameter int DEB_CYCLES    = 65536,
    parameter int ARP_TICKS     = 12500000,
    parameter int SIM_DIV_SHIFT = 0
) (
    input logic        CLK,
    input logic        RESET_N,
    piano_voice_if.slave bus
);
    localparam int NOTE_W = $clog2(NUM_KEYS + 1);

    logic [NUM_KEYS-1:0] sw_clean;
    logic [NOTE_W-1:0]   note_q, note_nx, prio_note;
    logic                note_valid;
    piano_state_t        state_q, state_nx;
    logic [DIV_W-1:0]    cnt_q, cnt_nx, half;
    logic                freq_q, freq_nx;
    logic [3:0]          tbl_idx;
    logic [31:0]         shifted;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
        piano_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (CLK),
            .rst_n(RESET_N),
            .raw  (bus.sw[k]),
            .clean(sw_clean[k])
        );
    end

    // Highest held index wins; note code is key index + 1.
    always_comb begin
        prio_note = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (sw_clean[k]) prio_note = NOTE_W'(k + 1);
        end
    end

`ifdef PIANO_ARP_EN
    localparam int AW = $clog2(ARP_TICKS + 1);

    logic [AW-1:0]     arp_cnt_q;
    logic              arp_on, arp_tick;
    logic [NOTE_W-1:0] below_note;

    // Next held key below the sounding one; falls back to the highest (wrap).
    always_comb begin
        below_note = prio_note;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (sw_clean[k] && (NOTE_W'(k + 1) < note_q)) below_note = NOTE_W'(k + 1);
        end
    end

    assign arp_on   = bus.arp_mode && ((sw_clean & (sw_clean - 1'b1)) != '0);
    assign arp_tick = (arp_cnt_q == AW'(ARP_TICKS - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                arp_cnt_q <= '0;
        else if (!arp_on || arp_tick) arp_cnt_q <= '0;
        else                         arp_cnt_q <= arp_cnt_q + 1'b1;
    end

    always_comb begin
        note_nx = prio_note;
        if (arp_on && (note_q != '0)) note_nx = arp_tick ? below_note : note_q;
    end
`else
    logic unused_arp;
    assign unused_arp = bus.arp_mode;
    assign note_nx    = prio_note;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) note_q <= '0;
        else          note_q <= note_nx;
    end

    assign note_valid = (note_q != NOTE_W'(NOTE_NONE));

    // Key k maps to table entry NUM_KEYS-1-k so the top key is the lowest pitch.
    always_comb begin
        tbl_idx = (note_q == '0) ? 4'd0 : 4'(NUM_KEYS - int'(note_q));
        shifted = (DIV_TABLE[tbl_idx] >> SIM_DIV_SHIFT) >> bus.octave;
        half    = (shifted == '0) ? DIV_W'(1) : shifted[DIV_W-1:0];
    end

    // Half-period length is only re-read at a toggle, so pitch changes never make runt pulses.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        freq_nx  = freq_q;
        unique case (state_q)
            ST_IDLE: begin
                freq_nx = 1'b0;
                if (note_valid) begin
                    cnt_nx   = half - 1'b1;
                    state_nx = ST_PLAY;
                end
            end
            ST_PLAY, ST_DRAIN: begin
                if (cnt_q != '0) begin
                    cnt_nx   = cnt_q - 1'b1;
                    state_nx = note_valid ? ST_PLAY : ST_DRAIN;
                end else if (note_valid) begin
                    freq_nx  = ~freq_q;
                    cnt_nx   = half - 1'b1;
                    state_nx = ST_PLAY;
                end else begin
                    freq_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            freq_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            freq_q  <= freq_nx;
        end
    end

    assign bus.FREQ       = freq_q;
    assign bus.note       = note_q;
    assign bus.note_valid = note_valid;
    assign bus.dbg_state  = state_q;

endmodule
